// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the Execute-stage RV32M divide unit.
package riscv_pkg;

  // Operation encoding as delivered on DivOpE: bit 0 = unsigned, bit 1 = remainder.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One radix-2 restoring iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] dvd_next,
  output logic            qbit
);

  logic [XLEN:0] trial;

  // Compare/subtract in XLEN+1 bits; the surviving remainder always fits XLEN bits
  // because the incoming remainder is strictly below the divisor.
  always_comb begin
    trial    = {rem, dvd[XLEN-1]};
    qbit     = (trial >= {1'b0, divisor});
    rem_next = qbit ? XLEN'(trial - {1'b0, divisor}) : trial[XLEN-1:0];
    dvd_next = {dvd[XLEN-2:0], qbit};
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) sitting beside the ALU in EX.
// Holds BusyE while working so the pipeline stalls; DoneE pulses for one cycle
// with the result on DivResultE, which then holds until the next completion.
//
// Handshake: StartE is sampled only in IDLE while KillE is low; BusyE is high in
// that acceptance cycle and throughout CALC, low in DONE so EX can advance with the
// result. KillE returns the unit to IDLE on the next edge from any state.
module ex_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [1:0]      DivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            KillE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] DivResultE,
  output logic [1:0]      state_dbg
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state, state_next;
  div_op_t         op_q;
  logic            qneg, rneg;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_q, dvd_q, div_q, hold_q;

  logic            signed_op, a_neg, b_neg, div_zero, ovf, start;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] rem_next, dvd_next;
  logic            qbit;
  logic [XLEN-1:0] q_fix, r_fix, result;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (div_q),
    .rem_next (rem_next),
    .dvd_next (dvd_next),
    .qbit     (qbit)
  );

  // Operand conditioning: magnitudes for signed ops and special-case detection.
  always_comb begin
    signed_op = ~DivOpE[0];
    a_neg     = signed_op & SrcAE[XLEN-1];
    b_neg     = signed_op & SrcBE[XLEN-1];
    abs_a     = a_neg ? (~SrcAE + 1'b1) : SrcAE;
    abs_b     = b_neg ? (~SrcBE + 1'b1) : SrcBE;
    div_zero  = (SrcBE == '0);
    ovf       = signed_op & (SrcAE == MIN_VAL) & (SrcBE == '1);
    start     = (state == IDLE) & StartE & ~KillE;
  end

  // Sign correction and quotient/remainder select. Special cases preload the
  // registers with final values and clear both sign flags, so they pass through.
  always_comb begin
    q_fix  = qneg ? (~dvd_q + 1'b1) : dvd_q;
    r_fix  = rneg ? (~rem_q + 1'b1) : rem_q;
    result = ((op_q == REM) || (op_q == REMU)) ? r_fix : q_fix;
  end

  // Next-state logic; KillE overrides everything and returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (div_zero || ovf) ? DONE : CALC;
      CALC:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (KillE) state_next = IDLE;
  end

  // State register plus operand, iteration and result-hold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= DIV;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      cnt    <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      div_q  <= '0;
      hold_q <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        op_q <= div_op_t'(DivOpE);
        if (div_zero) begin
          dvd_q <= '1;
          rem_q <= SrcAE;
          qneg  <= 1'b0;
          rneg  <= 1'b0;
        end else if (ovf) begin
          dvd_q <= MIN_VAL;
          rem_q <= '0;
          qneg  <= 1'b0;
          rneg  <= 1'b0;
        end else begin
          dvd_q <= abs_a;
          div_q <= abs_b;
          rem_q <= '0;
          qneg  <= a_neg ^ b_neg;
          rneg  <= a_neg;
          cnt   <= CNT_W'(XLEN - 1);
        end
      end else if (state == CALC) begin
        rem_q <= rem_next;
        dvd_q <= dvd_next;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (state == DONE) hold_q <= result;
    end
  end

  // Outputs: result is live during DONE and held afterwards.
  always_comb begin
    BusyE      = ~reset & (start | (state == CALC));
    DoneE      = ~reset & (state == DONE);
    DivResultE = DoneE ? result : hold_q;
    state_dbg  = state;
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: drivers push expected results, latency and
// stall length into queues; a negedge monitor pops and compares on each DoneE.
module tb_ex_div_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE = 1'b0;
  logic [1:0]  DivOpE = 2'b00;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        KillE = 1'b0;
  logic        BusyE, DoneE;
  logic [31:0] DivResultE;
  logic [1:0]  state_dbg;

  ex_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .StartE     (StartE),
    .DivOpE     (DivOpE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .KillE      (KillE),
    .BusyE      (BusyE),
    .DoneE      (DoneE),
    .DivResultE (DivResultE),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter (cyc = number of rising edges so far).
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues.
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_busy_q[$];
  int          probe_cyc_q[$];
  logic        probe_busy_q[$];
  logic [1:0]  probe_st_q[$];
  logic [31:0] probe_res_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (DoneE) begin
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", DivResultE, exp_q.pop_front());
        chk("done_cycle", cyc, exp_cyc_q.pop_front());
        chk("busy_cycles", busy_run, exp_busy_q.pop_front());
      end
    end
    if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
      chk("done_timeout", 32'd1, 32'd0);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      void'(exp_busy_q.pop_front());
    end
    while (probe_cyc_q.size() > 0 && probe_cyc_q[0] <= cyc) begin
      void'(probe_cyc_q.pop_front());
      chk("probe_busy", {31'b0, BusyE}, {31'b0, probe_busy_q.pop_front()});
      chk("probe_state", {30'b0, state_dbg}, {30'b0, probe_st_q.pop_front()});
      chk("probe_result", DivResultE, probe_res_q.pop_front());
      chk("probe_done", {31'b0, DoneE}, 32'd0);
    end
    busy_run  = BusyE ? busy_run + 1 : 0;
    prev_done = DoneE;
  end

  task automatic push_probe(input int at, input logic busy, input logic [1:0] st, input logic [31:0] res);
    probe_cyc_q.push_back(at);
    probe_busy_q.push_back(busy);
    probe_st_q.push_back(st);
    probe_res_q.push_back(res);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one divide and wait for the first IDLE cycle after its DONE.
  // Called just after a rising edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special);
    int s, lat;
    StartE = 1'b1; DivOpE = op; SrcAE = a; SrcBE = b;
    tick();
    s = cyc;
    StartE = 1'b0;
    lat = special ? 0 : 32;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(s + lat);
    exp_busy_q.push_back(special ? 1 : 33);
    last_res = exp;
    do tick(); while (cyc < s + lat + 1);
  endtask

  // Start a long divide, then abort it with KillE or reset after 10 cycles.
  task automatic abort_run(input bit use_reset);
    int s;
    StartE = 1'b1; DivOpE = DIVU; SrcAE = 32'd1000; SrcBE = 32'd3;
    tick();
    s = cyc;
    StartE = 1'b0;
    while (cyc < s + 9) tick();
    if (use_reset) reset = 1'b1; else KillE = 1'b1;
    tick();
    reset = 1'b0; KillE = 1'b0;
    if (use_reset) last_res = '0;
    push_probe(cyc, 1'b0, 2'(IDLE), last_res);
    repeat (40) tick();
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    push_probe(cyc, 1'b0, 2'(IDLE), 32'd0);
    tick();

    issue(DIVU, 32'd100, 32'd7, 32'd14, 0);
    issue(REMU, 32'd100, 32'd7, 32'd2, 0);
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    issue(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    issue(REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 0);
    issue(DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 0);
    issue(REM,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0);
    issue(DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 0);
    issue(REMU, 32'h8000_0000, 32'd3, 32'd2, 0);

    issue(DIVU, 32'h1234_5678, 32'd0, DIV_BY_ZERO_Q, 1);
    issue(REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    issue(REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    issue(DIV,  32'hFFFF_FFFB, 32'd0, DIV_BY_ZERO_Q, 1);
    issue(DIV,  INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1);
    issue(REM,  INT_MIN, 32'hFFFF_FFFF, 32'd0, 1);
    issue(DIVU, INT_MIN, 32'hFFFF_FFFF, 32'd0, 0);
    issue(REMU, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 0);

    // KillE mid-CALC, then KillE together with StartE in IDLE.
    abort_run(0);
    StartE = 1'b1; KillE = 1'b1; DivOpE = DIVU; SrcAE = 32'd9; SrcBE = 32'd3;
    tick();
    StartE = 1'b0; KillE = 1'b0;
    push_probe(cyc, 1'b0, 2'(IDLE), last_res);
    repeat (40) tick();

    // Reset mid-CALC clears the held result.
    abort_run(1);

    // Back-to-back: second start in the first IDLE cycle after DONE.
    issue(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0);
    issue(REMU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 0);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative RV32M divide unit in the Execute stage, directly downstream of the ALU source-B select.
- Consumes SrcAE and the selected SrcBE, and performs DIV/DIVU/REM/REMU with a radix-2 restoring algorithm.
- Holds BusyE high so the hazard unit stalls F/D/E until the result is ready.
- The result is merged into the EX result path alongside ALUResultE.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- StartE  input  1  EX holds a valid divide-class instruction.
- DivOpE  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- SrcAE  input  XLEN  dividend (rs1, post-forwarding).
- SrcBE  input  XLEN  divisor (output of ALU source-B select).
- KillE  input  1  synchronous abort of the in-flight operation (EX flush).
- BusyE  output  1  stall request to hazard unit.
- DoneE  output  1  one-cycle pulse: DivResultE valid.
- DivResultE  output  XLEN  quotient or remainder per DivOpE.

Behaviour:
- Reset: synchronous, active-high, one clock; the team names the ports clk and reset. State=IDLE, DoneE=0, DivResultE=0, counter=0, internal regs=0. BusyE=0 while reset is high.
- States: IDLE, CALC, DONE.
- IDLE, StartE=1, KillE=0:
  - Latch DivOpE.
  - Signed ops: latch |SrcAE|, |SrcBE|, plus sign flags qneg = A[31]^B[31] and rneg = A[31]. Unsigned ops: raw operands, flags=0.
  - Special cases go to DONE next cycle with the result preloaded:
    - SrcBE==0: quotient = 0xFFFFFFFF, remainder = SrcAE (all ops).
    - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
  - Otherwise: load counter = XLEN-1, partial remainder = 0, go to CALC.
- CALC, one bit per cycle:
  - rem' = {rem[XLEN-1:0], dvd[MSB]} (XLEN+1 bits); dvd shifts left.
  - If rem' >= divisor: rem = rem' - divisor and shift 1 into the quotient; else rem = rem' and shift 0.
  - When counter==0, go to DONE; else decrement.
  - Exactly XLEN CALC cycles.
- DONE:
  - Apply sign correction on the normal path only: quotient negated if qneg; remainder negated if rneg.
  - Drive DivResultE = quotient (DIV/DIVU) or remainder (REM/REMU); DoneE=1 for this cycle only.
  - Unconditionally go to IDLE.
  - DivResultE holds its value until the next DONE.
- BusyE (combinational) = (IDLE & StartE & ~KillE) | CALC. It is 0 in DONE so EX advances that cycle; StartE still high in DONE does not restart the unit.
- Latency: StartE sampled at edge 0 → DoneE in cycle XLEN+1 (33). Special cases → DoneE in cycle 1. Stall cycles seen by the pipeline: 33 normal, 1 special.
- KillE: any state → IDLE next edge with no DoneE; DivResultE is unchanged. KillE with StartE in IDLE does not start. KillE outranks StartE.
- reset mid-CALC: return to reset values next edge; no DoneE.
- Back-to-back divides: a second StartE is accepted in the first IDLE cycle after DONE.
- Arithmetic: all compare/subtract in XLEN+1 bits. Negation is two's complement modulo 2^XLEN.

Decomposition:
- Shared package (riscv_pkg): div_op_t enum {DIV, DIVU, REM, REMU}; div_state_t enum {IDLE, CALC, DONE}; constants DIV_BY_ZERO_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000.
- Optional sub-module div_step: combinational single restoring iteration (rem, dvd, divisor in; rem_next, dvd_next, qbit out). FSM, counter and sign handling stay in ex_div_unit.

Test Plan:
- DIVU 100/7 → DoneE at cycle 33, DivResultE=14; REMU same operands → 2; BusyE high cycles 0-32.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); REM 7 / 0xFFFFFFFE → 1.
- DIVU 0x12345678 / 0 → 0xFFFFFFFF at cycle 1; REM 0x12345678 / 0 → 0x12345678; BusyE high 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1; REM → 0.
- Start DIVU 1000/3, assert KillE at cycle 10 → IDLE at cycle 11, no DoneE, BusyE=0. Repeat with reset at cycle 10 → same outcome, DivResultE=0.
- Back-to-back: DIVU 0xFFFFFFFF/1 then REMU 0xFFFFFFFF/16 → 0xFFFFFFFF at cycle 33, 0xF at cycle 67; DoneE exactly one cycle each.
